// File: rtl/trap_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | trap_ctrl_if : trap sequencer <-> CSR block port bundle                    |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

interface trap_ctrl_if;
    logic [31:0] csr_info;
    logic [31:0] csr_rdata;
    logic        except;
    logic        interrupt;
    logic [31:0] except_info;
    logic        csr_req;
    logic [11:0] csr_addr;
    logic        csr_w;
    logic [31:0] csr_wdata;

    modport master (
        input  csr_info, csr_rdata,
        output except, interrupt, except_info, csr_req, csr_addr, csr_w, csr_wdata
    );

    modport slave (
        output csr_info, csr_rdata,
        input  except, interrupt, except_info, csr_req, csr_addr, csr_w, csr_wdata
    );
endinterface

`default_nettype wire

// File: rtl/trap_ctrl.sv
// +----------------------------------------------------------------------------+
// | trap_ctrl : RV32I trap/MRET sequencer driving the CSR block trap port.     |
// | Interrupt path enabled by defining TRAP_CTRL_IRQ_EN.                       |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module trap_ctrl #(
    parameter logic [31:0] MTVEC_ALIGN_MASK = 32'hFFFF_FFFC
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [31:0] pc_i,
    input  wire logic        illegal_instr_i,
    input  wire logic        ebreak_i,
    input  wire logic        ecall_i,
    input  wire logic        misaligned_i,
    input  wire logic        mret_i,
    input  wire logic        ext_irq_i,
    input  wire logic        timer_irq_i,
    trap_ctrl_if.master      csr,
    output logic             stall_o,
    output logic             flush_o,
    output logic             pc_redirect_o,
    output logic [31:0]      pc_target_o
);

    localparam logic [11:0] C_ADDR_MSTATUS = 12'h000;
    localparam logic [11:0] C_ADDR_MEPC    = 12'h002;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TRAP     = 3'd1,
        S_MRET_RD  = 3'd2,
        S_MRET_WR  = 3'd3,
        S_REDIRECT = 3'd4
    } state_t;

    state_t      state_q;
    logic        except_q, interrupt_q, csr_req_q, csr_w_q;
    logic        stall_q, flush_q, redirect_q;
    logic [31:0] except_info_q, csr_wdata_q, pc_target_q;
    logic [11:0] csr_addr_q;

    logic [15:0] mstatus, mip;
    logic        ext_take, timer_take;
    logic        trap_d, irq_d;
    logic [6:0]  cause_d;
    logic [7:0]  mst_trap_d;
    logic [31:0] mst_mret_d;

    assign mstatus = csr.csr_info[15:0];
    assign mip     = csr.csr_info[31:16];

`ifdef TRAP_CTRL_IRQ_EN
    assign ext_take   = ext_irq_i   & mstatus[3] & mip[11];
    assign timer_take = timer_irq_i & mstatus[3] & mip[7];
`else
    assign ext_take   = 1'b0;
    assign timer_take = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{pc_i[31:16], mip, ext_irq_i, timer_irq_i};

    always_comb begin
        trap_d  = 1'b1;
        irq_d   = 1'b0;
        cause_d = 7'd0;
        if (illegal_instr_i)    cause_d = 7'd2;
        else if (ebreak_i)      cause_d = 7'd3;
        else if (ecall_i)       cause_d = 7'd11;
        else if (misaligned_i)  cause_d = 7'd4;
        else if (ext_take)      begin cause_d = 7'd11; irq_d = 1'b1; end
        else if (timer_take)    begin cause_d = 7'd7;  irq_d = 1'b1; end
        else                    trap_d = 1'b0;
    end

    // Trap entry: MPIE <- MIE, MIE <- 0. MRET: MIE <- MPIE, MPIE <- 1.
    assign mst_trap_d = {mstatus[3], mstatus[6:4], 1'b0, mstatus[2:0]};
    assign mst_mret_d = {16'h0000, mstatus[15:8], 1'b1, mstatus[6:4], mstatus[7], mstatus[2:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            except_q      <= 1'b0;
            interrupt_q   <= 1'b0;
            except_info_q <= 32'h0;
            csr_req_q     <= 1'b0;
            csr_addr_q    <= 12'h000;
            csr_w_q       <= 1'b0;
            csr_wdata_q   <= 32'h0;
            stall_q       <= 1'b0;
            flush_q       <= 1'b0;
            redirect_q    <= 1'b0;
            pc_target_q   <= 32'h0;
        end else begin
            except_q    <= 1'b0;
            interrupt_q <= 1'b0;
            csr_req_q   <= 1'b0;
            csr_w_q     <= 1'b0;
            flush_q     <= 1'b0;
            redirect_q  <= 1'b0;
            stall_q     <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (trap_d) begin
                        state_q       <= S_TRAP;
                        except_q      <= 1'b1;
                        interrupt_q   <= irq_d;
                        except_info_q <= {irq_d, cause_d, mst_trap_d, pc_i[15:0]};
                    end else if (mret_i) begin
                        state_q    <= S_MRET_RD;
                        csr_req_q  <= 1'b1;
                        csr_addr_q <= C_ADDR_MEPC;
                    end else begin
                        stall_q <= 1'b0;
                    end
                end
                S_TRAP: begin
                    // CSR block presents mtvec while except is high
                    pc_target_q <= csr.csr_rdata & MTVEC_ALIGN_MASK;
                    redirect_q  <= 1'b1;
                    flush_q     <= 1'b1;
                    state_q     <= S_REDIRECT;
                end
                S_MRET_RD: begin
                    pc_target_q <= csr.csr_rdata;
                    csr_req_q   <= 1'b1;
                    csr_w_q     <= 1'b1;
                    csr_addr_q  <= C_ADDR_MSTATUS;
                    csr_wdata_q <= mst_mret_d;
                    state_q     <= S_MRET_WR;
                end
                S_MRET_WR: begin
                    redirect_q <= 1'b1;
                    flush_q    <= 1'b1;
                    state_q    <= S_REDIRECT;
                end
                S_REDIRECT: begin
                    stall_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    stall_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign csr.except      = except_q;
    assign csr.interrupt   = interrupt_q;
    assign csr.except_info = except_info_q;
    assign csr.csr_req     = csr_req_q;
    assign csr.csr_addr    = csr_addr_q;
    assign csr.csr_w       = csr_w_q;
    assign csr.csr_wdata   = csr_wdata_q;
    assign stall_o         = stall_q;
    assign flush_o         = flush_q;
    assign pc_redirect_o   = redirect_q;
    assign pc_target_o     = pc_target_q;

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_trap_ctrl : randomized + directed bench for trap_ctrl with a queue-based |
// | reference model of the per-cycle output sequence.                          |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_trap_ctrl;
    localparam logic [31:0] MASK = 32'hFFFF_FFFC;
`ifdef TRAP_CTRL_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        ill, ebr, ecl, mis, mret, ext, tmr;
    logic        stall, flush, redir;
    logic [31:0] tgt;
    logic [15:0] mst, mip;
    logic [31:0] mtvec, mepc;

    trap_ctrl_if csr();

    trap_ctrl #(.MTVEC_ALIGN_MASK(MASK)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_i            (pc),
        .illegal_instr_i (ill),
        .ebreak_i        (ebr),
        .ecall_i         (ecl),
        .misaligned_i    (mis),
        .mret_i          (mret),
        .ext_irq_i       (ext),
        .timer_irq_i     (tmr),
        .csr             (csr),
        .stall_o         (stall),
        .flush_o         (flush),
        .pc_redirect_o   (redir),
        .pc_target_o     (tgt)
    );

    always #5 clk = ~clk;

    // CSR block stand-in: mepc on a read of 0x002, otherwise mtvec
    assign csr.csr_info  = {mip, mst};
    assign csr.csr_rdata = (csr.csr_req && csr.csr_addr == 12'h002) ? mepc : mtvec;

    typedef struct packed {
        logic        busy, exc, irq, req, w, stall, flush, redir;
        logic [31:0] info, wdata, tgt;
        logic [11:0] addr;
    } exp_t;

    exp_t cur;
    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t idle_e();
        exp_t e;
        e = '0;
        return e;
    endfunction

    // Expected output sequence for an event seen by an idle sequencer
    task automatic model_sample();
        logic [6:0]  cause;
        logic        trap, irq;
        logic [7:0]  nb;
        logic [31:0] wd;
        exp_t        e;
        trap = 1'b1; irq = 1'b0; cause = 7'd0;
        if (ill)      cause = 7'd2;
        else if (ebr) cause = 7'd3;
        else if (ecl) cause = 7'd11;
        else if (mis) cause = 7'd4;
        else if (IRQ_EN && ext && mst[3] && mip[11]) begin cause = 7'd11; irq = 1'b1; end
        else if (IRQ_EN && tmr && mst[3] && mip[7])  begin cause = 7'd7;  irq = 1'b1; end
        else trap = 1'b0;
        if (trap) begin
            nb = mst[7:0]; nb[7] = mst[3]; nb[3] = 1'b0;
            e = idle_e(); e.busy = 1; e.stall = 1; e.exc = 1; e.irq = irq;
            e.info = {irq, cause, nb, pc[15:0]};
            q.push_back(e);
            e = idle_e(); e.busy = 1; e.stall = 1; e.flush = 1; e.redir = 1; e.tgt = mtvec & MASK;
            q.push_back(e);
        end else if (mret) begin
            e = idle_e(); e.busy = 1; e.stall = 1; e.req = 1; e.addr = 12'h002;
            q.push_back(e);
            wd = {16'h0000, mst}; wd[7] = 1'b1; wd[3] = mst[7];
            e = idle_e(); e.busy = 1; e.stall = 1; e.req = 1; e.w = 1; e.addr = 12'h000; e.wdata = wd;
            q.push_back(e);
            e = idle_e(); e.busy = 1; e.stall = 1; e.flush = 1; e.redir = 1; e.tgt = mepc;
            q.push_back(e);
        end
    endtask

    task automatic compare();
        chk("except",    {31'h0, csr.except},    {31'h0, cur.exc});
        chk("interrupt", {31'h0, csr.interrupt}, {31'h0, cur.irq});
        chk("csr_req",   {31'h0, csr.csr_req},   {31'h0, cur.req});
        chk("csr_w",     {31'h0, csr.csr_w},     {31'h0, cur.w});
        chk("stall",     {31'h0, stall},         {31'h0, cur.stall});
        chk("flush",     {31'h0, flush},         {31'h0, cur.flush});
        chk("redirect",  {31'h0, redir},         {31'h0, cur.redir});
        if (cur.exc)   chk("except_info", csr.except_info, cur.info);
        if (cur.req)   chk("csr_addr", {20'h0, csr.csr_addr}, {20'h0, cur.addr});
        if (cur.w)     chk("csr_wdata", csr.csr_wdata, cur.wdata);
        if (cur.redir) chk("pc_target", tgt, cur.tgt);
    endtask

    task automatic tick();
        if (!cur.busy) model_sample();
        @(posedge clk);
        @(negedge clk);
        if (q.size() > 0) cur = q.pop_front();
        else              cur = idle_e();
        compare();
    endtask

    task automatic clr();
        ill = 0; ebr = 0; ecl = 0; mis = 0; mret = 0; ext = 0; tmr = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " except"},      {31'h0, csr.except},    32'h0);
        chk({tag, " interrupt"},   {31'h0, csr.interrupt}, 32'h0);
        chk({tag, " except_info"}, csr.except_info,        32'h0);
        chk({tag, " csr_req"},     {31'h0, csr.csr_req},   32'h0);
        chk({tag, " csr_addr"},    {20'h0, csr.csr_addr},  32'h0);
        chk({tag, " csr_w"},       {31'h0, csr.csr_w},     32'h0);
        chk({tag, " csr_wdata"},   csr.csr_wdata,          32'h0);
        chk({tag, " stall"},       {31'h0, stall},         32'h0);
        chk({tag, " flush"},       {31'h0, flush},         32'h0);
        chk({tag, " redirect"},    {31'h0, redir},         32'h0);
        chk({tag, " pc_target"},   tgt,                    32'h0);
    endtask

    initial begin
        rst = 1'b1; clr();
        pc = 0; mst = 0; mip = 0; mtvec = 0; mepc = 0;
        cur = idle_e();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // illegal instruction, mtvec low bits masked off
        pc = 32'h0000_0124; mtvec = 32'h0000_0203; ill = 1;
        tick(); clr();
        chk("t1 except", {31'h0, csr.except}, 32'h1);
        chk("t1 info", csr.except_info, 32'h0200_0124);
        tick();
        chk("t1 redirect", {31'h0, redir}, 32'h1);
        chk("t1 target", tgt, 32'h0000_0200);
        tick();

        // ecall beats misaligned
        pc = 32'h0000_0300; ecl = 1; mis = 1;
        tick(); clr();
        chk("t2 cause", {25'h0, csr.except_info[30:24]}, 32'd11);
        tick(); tick();
        chk("t2 single trap", {31'h0, csr.except}, 32'h0);

        // external interrupt, enabled
        mst = 16'h0008; mip = 16'h0800; pc = 32'h0000_0040; ext = 1;
        tick(); clr();
`ifdef TRAP_CTRL_IRQ_EN
        chk("t3 interrupt", {31'h0, csr.interrupt}, 32'h1);
        chk("t3 info", csr.except_info, 32'h8B80_0040);
`else
        chk("t3 ignored", {31'h0, csr.except}, 32'h0);
`endif
        tick(); tick();

        // same interrupt with MIE=0
        mst = 16'h0000; ext = 1;
        tick(); tick(); clr();
        chk("t4 stall", {31'h0, stall}, 32'h0);
        chk("t4 except", {31'h0, csr.except}, 32'h0);

        // mret sequence
        mepc = 32'h0000_0128; mst = 16'h0080; mip = 16'h0000; mret = 1;
        tick(); clr();
        chk("t5 rd addr", {20'h0, csr.csr_addr}, 32'h002);
        tick();
        chk("t5 wr addr", {20'h0, csr.csr_addr}, 32'h000);
        chk("t5 wdata", csr.csr_wdata, 32'h0000_0088);
        tick();
        chk("t5 target", tgt, 32'h0000_0128);
        chk("t5 redirect", {31'h0, redir}, 32'h1);
        tick();

        // reset during TRAP aborts the sequence
        pc = 32'h0000_0500; mst = 0; ill = 1;
        tick(); clr();
        #1 rst = 1'b1;
        #1 chk_all_zero("rst async");
        @(negedge clk);
        chk_all_zero("rst next");
        rst = 1'b0;
        q.delete();
        cur = idle_e();
        pc = 32'h0000_0088; ebr = 1;
        tick(); clr();
        chk("t6 cause", {25'h0, csr.except_info[30:24]}, 32'd3);
        tick(); tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!cur.busy) begin
                mst   = 16'($urandom);
                mip   = 16'($urandom);
                mtvec = $urandom;
                mepc  = $urandom;
                pc    = $urandom;
            end
            ill  = ($urandom_range(0, 11) == 0);
            ebr  = ($urandom_range(0, 11) == 0);
            ecl  = ($urandom_range(0, 11) == 0);
            mis  = ($urandom_range(0, 11) == 0);
            mret = ($urandom_range(0, 5) == 0);
            ext  = ($urandom_range(0, 3) == 0);
            tmr  = ($urandom_range(0, 3) == 0);
            tick();
        end
        clr();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
